mem_arbiter: RTL and testbench

//  Round-robin arbiter between N_PROC SIMD proc instances and the single-port shared data memory.
//  - Grants reads with a lock: the owner keeps the port for its FETCH1 -> FETCH2 pair, since FETCH2

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the shared-memory arbiter.
`default_nettype none

package mem_arbiter_pkg;

    localparam int N_PROC_DEF = 4;
    localparam int PROC_ID_W  = $clog2(N_PROC_DEF);
    localparam int ADDR_W     = 16;
    localparam int BUS_W      = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_kind_t;

    // Successor of idx in a ring of n slots.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping N-1 -> 0.
`default_nettype none

module mem_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] slot;

    // Scan from the farthest slot back to start so the nearest hit is written last.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            slot = ID_W'((int'(start) + k) % N);
            if (req[slot]) begin
                vld = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between proc requesters and the single-port data memory.
// Optional ARB_WR_PRIO_EN: pending writes beat all reads on a free edge.
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_PROC = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [N_PROC-1:0] i_req_rd,
    input  logic [N_PROC-1:0] i_req_wr,
    input  logic [N_PROC-1:0] i_wr_en,
    input  addr_t             i_addr    [N_PROC],
    input  logic [BUS_W-1:0]  i_wdata   [N_PROC],
    input  logic [2:0]        i_wr_size [N_PROC],
    output logic [N_PROC-1:0] o_grant_rd,
    output logic [N_PROC-1:0] o_grant_wr,
    output logic [BUS_W-1:0]  o_rdata,
    output addr_t             o_mem_addr,
    output logic [BUS_W-1:0]  o_mem_wdata,
    output logic [2:0]        o_mem_wr_size,
    output logic              o_mem_wr_en,
    input  logic [BUS_W-1:0]  i_mem_rdata
);

    localparam int ID_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    logic            own_vld;
    logic [ID_W-1:0] own_id;
    arb_kind_t       own_kind;
    logic [ID_W-1:0] rr_ptr;

    logic            free;
    logic [N_PROC-1:0] any_req;
    logic            any_vld;
    logic [ID_W-1:0] any_idx;
    logic            pick_vld;
    logic [ID_W-1:0] pick_idx;

    assign any_req = i_req_rd | i_req_wr;

    mem_arbiter_rr_pick #(
        .N    (N_PROC),
        .ID_W (ID_W)
    ) u_pick_any (
        .req   (any_req),
        .start (rr_ptr),
        .vld   (any_vld),
        .idx   (any_idx)
    );

`ifdef ARB_WR_PRIO_EN
    logic            wr_vld;
    logic [ID_W-1:0] wr_idx;

    mem_arbiter_rr_pick #(
        .N    (N_PROC),
        .ID_W (ID_W)
    ) u_pick_wr (
        .req   (i_req_wr),
        .start (rr_ptr),
        .vld   (wr_vld),
        .idx   (wr_idx)
    );

    assign pick_vld = wr_vld | any_vld;
    assign pick_idx = wr_vld ? wr_idx : any_idx;
`else
    assign pick_vld = any_vld;
    assign pick_idx = any_idx;
`endif

    // A read owner keeps the port while it still requests; a write owner always lets go.
    assign free = !own_vld
                | ((own_kind == ARB_RD) && !i_req_rd[own_id])
                | (own_kind == ARB_WR);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            own_vld  <= 1'b0;
            own_id   <= '0;
            own_kind <= ARB_RD;
            rr_ptr   <= '0;
        end else if (free) begin
            if (pick_vld) begin
                own_vld  <= 1'b1;
                own_id   <= pick_idx;
                own_kind <= i_req_wr[pick_idx] ? ARB_WR : ARB_RD;
                rr_ptr   <= ID_W'(wrap_inc(int'(pick_idx), N_PROC));
            end else begin
                own_vld  <= 1'b0;
            end
        end
    end

    always_comb begin
        o_grant_rd = '0;
        o_grant_wr = '0;
        for (int i = 0; i < N_PROC; i++) begin
            o_grant_rd[i] = own_vld && (own_id == ID_W'(i)) && (own_kind == ARB_RD) && i_req_rd[i];
            o_grant_wr[i] = own_vld && (own_id == ID_W'(i)) && (own_kind == ARB_WR) && i_req_wr[i];
        end
    end

    assign o_mem_wr_en   = o_grant_wr[own_id] & i_wr_en[own_id];
    assign o_mem_addr    = own_vld ? i_addr[own_id]    : '0;
    assign o_mem_wdata   = own_vld ? i_wdata[own_id]   : '0;
    assign o_mem_wr_size = own_vld ? i_wr_size[own_id] : '0;
    assign o_rdata       = i_mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle expected port state queued and compared.
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_rd, req_wr, wr_en;
    addr_t            addr    [4];
    logic [BUS_W-1:0] wdata   [4];
    logic [2:0]       wr_size [4];
    logic [3:0]       grant_rd, grant_wr;
    logic [BUS_W-1:0] rdata, mem_wdata, mem_rdata;
    addr_t            mem_addr;
    logic [2:0]       mem_wr_size;
    logic             mem_wr_en;

    int nchk  = 0;
    int npass = 0;

    typedef struct packed {
        logic [3:0]       grd;
        logic [3:0]       gwr;
        addr_t            addr;
        logic [BUS_W-1:0] wdata;
        logic             wen;
        logic [2:0]       size;
    } obs_t;

    // own = 4 means no owner expected
    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] wr;
        logic [3:0] we;
        addr_t      a0;
        logic [2:0] own;
        logic [3:0] grd;
        logic [3:0] gwr;
        logic       wen;
    } row_t;

    obs_t sbq [$];

    mem_arbiter #(.N_PROC(4)) dut (
        .i_clk         (clk),
        .i_rstn        (rst_n),
        .i_req_rd      (req_rd),
        .i_req_wr      (req_wr),
        .i_wr_en       (wr_en),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .i_wr_size     (wr_size),
        .o_grant_rd    (grant_rd),
        .o_grant_wr    (grant_wr),
        .o_rdata       (rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_wr_size (mem_wr_size),
        .o_mem_wr_en   (mem_wr_en),
        .i_mem_rdata   (mem_rdata)
    );

    assign mem_rdata = {16'hA5A5, mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {grant_rd, grant_wr, mem_addr, mem_wdata, mem_wr_en, mem_wr_size};
    endfunction

    function automatic obs_t expect_of(input row_t r);
        obs_t e;
        e       = '0;
        e.grd   = r.grd;
        e.gwr   = r.gwr;
        e.wen   = r.wen;
        if (r.own < 3'd4) begin
            e.addr  = addr[r.own[1:0]];
            e.wdata = wdata[r.own[1:0]];
            e.size  = wr_size[r.own[1:0]];
        end
        return e;
    endfunction

    task automatic apply(input row_t r);
        req_rd  = r.rd;
        req_wr  = r.wr;
        wr_en   = r.we;
        addr[0] = r.a0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_rd = '0; req_wr = '0; wr_en = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_rd = '0; req_wr = '0; wr_en = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n  = 1'b0;
        req_rd = 4'b1111; req_wr = 4'b1111; wr_en = 4'b1111;
        repeat (2) @(negedge clk);
        nchk++;
        if ({grant_rd, grant_wr} !== 8'h00)
            $display("FAIL reset_grants: got rd=%b wr=%b, expected 0000 0000", grant_rd, grant_wr);
        else npass++;
        nchk++;
        if ({mem_wr_en, mem_addr} !== 17'h0)
            $display("FAIL reset_mem: got wen=%b addr=%h, expected 0 0000", mem_wr_en, mem_addr);
        else npass++;
        req_rd = '0; req_wr = '0; wr_en = '0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sbq.push_back('0);
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL reset_idle c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
    endtask

    task automatic test_single_proc();
        row_t rows [7];
        obs_t o, e;
        wr_size[0] = 3'd5;
        rows = '{
            '{4'b0001, 4'b0000, 4'b0000, 16'h0010, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b0001, 4'b0000, 4'b0000, 16'h0010, 3'd0, 4'b0001, 4'b0000, 1'b0},
            '{4'b0001, 4'b0000, 4'b0000, 16'h0020, 3'd0, 4'b0001, 4'b0000, 1'b0},
            '{4'b0000, 4'b0001, 4'b0001, 16'h0030, 3'd0, 4'b0000, 4'b0000, 1'b0},
            '{4'b0000, 4'b0001, 4'b0001, 16'h0030, 3'd0, 4'b0000, 4'b0001, 1'b1},
            '{4'b0000, 4'b0000, 4'b0001, 16'h0030, 3'd0, 4'b0000, 4'b0000, 1'b0},
            '{4'b0000, 4'b0000, 4'b0001, 16'h0030, 3'd4, 4'b0000, 4'b0000, 1'b0}
        };
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            apply(rows[c]);
            sbq.push_back(expect_of(rows[c]));
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL single_proc c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
    endtask

    task automatic test_two_procs();
        row_t rows [10];
        obs_t o, e;
        do_reset();
        addr[1] = 16'h0200; wr_size[0] = 3'd2; wr_size[1] = 3'd7;
        rows = '{
            '{4'b0011, 4'b0000, 4'b0000, 16'h0100, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b0011, 4'b0000, 4'b0000, 16'h0100, 3'd0, 4'b0001, 4'b0000, 1'b0},
            '{4'b0011, 4'b0000, 4'b0000, 16'h0100, 3'd0, 4'b0001, 4'b0000, 1'b0},
            '{4'b0010, 4'b0001, 4'b0001, 16'h0100, 3'd0, 4'b0000, 4'b0000, 1'b0},
            '{4'b0010, 4'b0001, 4'b0001, 16'h0100, 3'd1, 4'b0010, 4'b0000, 1'b0},
            '{4'b0010, 4'b0001, 4'b0001, 16'h0100, 3'd1, 4'b0010, 4'b0000, 1'b0},
            '{4'b0000, 4'b0011, 4'b0011, 16'h0100, 3'd1, 4'b0000, 4'b0000, 1'b0},
            '{4'b0000, 4'b0011, 4'b0011, 16'h0100, 3'd0, 4'b0000, 4'b0001, 1'b1},
            '{4'b0001, 4'b0010, 4'b0010, 16'h0100, 3'd1, 4'b0000, 4'b0010, 1'b1},
            '{4'b0001, 4'b0000, 4'b0000, 16'h0100, 3'd0, 4'b0001, 4'b0000, 1'b0}
        };
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            apply(rows[c]);
            sbq.push_back(expect_of(rows[c]));
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL two_procs c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
    endtask

    task automatic test_lock_drop();
        row_t rows [5];
        obs_t o, e;
        logic [BUS_W-1:0] exp_rdata;
        addr[2] = 16'h002A; addr[3] = 16'h003B;
        rows = '{
            '{4'b1100, 4'b0000, 4'b0000, 16'h0100, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b1100, 4'b0000, 4'b0000, 16'h0100, 3'd2, 4'b0100, 4'b0000, 1'b0},
            '{4'b1000, 4'b0000, 4'b0000, 16'h0100, 3'd2, 4'b0000, 4'b0000, 1'b0},
            '{4'b1000, 4'b0000, 4'b0000, 16'h0100, 3'd3, 4'b1000, 4'b0000, 1'b0},
            '{4'b1000, 4'b0000, 4'b0000, 16'h0100, 3'd3, 4'b1000, 4'b0000, 1'b0}
        };
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            apply(rows[c]);
            sbq.push_back(expect_of(rows[c]));
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL lock_drop c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
        exp_rdata = 32'hA5A5_003B;
        nchk++;
        if (rdata !== exp_rdata) $display("FAIL rdata_bcast: got %h, expected %h", rdata, exp_rdata);
        else npass++;
    endtask

    task automatic test_wr_prio();
        row_t rows [3];
        obs_t o, e;
        do_reset();
        addr[1] = 16'h0211; addr[2] = 16'h0222;
`ifdef ARB_WR_PRIO_EN
        rows = '{
            '{4'b0101, 4'b0010, 4'b0010, 16'h0100, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b0101, 4'b0010, 4'b0010, 16'h0100, 3'd1, 4'b0000, 4'b0010, 1'b1},
            '{4'b0101, 4'b0000, 4'b0000, 16'h0100, 3'd1, 4'b0000, 4'b0000, 1'b0}
        };
`else
        rows = '{
            '{4'b0101, 4'b0010, 4'b0010, 16'h0100, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b0101, 4'b0010, 4'b0010, 16'h0100, 3'd0, 4'b0001, 4'b0000, 1'b0},
            '{4'b0101, 4'b0000, 4'b0000, 16'h0100, 3'd0, 4'b0001, 4'b0000, 1'b0}
        };
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            apply(rows[c]);
            sbq.push_back(expect_of(rows[c]));
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL wr_prio c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
    endtask

    task automatic test_async_reset();
        row_t rows [2];
        obs_t o, e;
        addr[3] = 16'h0077; wr_size[3] = 3'd3;
        rows = '{
            '{4'b0000, 4'b1000, 4'b1000, 16'h0100, 3'd4, 4'b0000, 4'b0000, 1'b0},
            '{4'b0000, 4'b1000, 4'b1000, 16'h0100, 3'd3, 4'b0000, 4'b1000, 1'b1}
        };
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            apply(rows[c]);
            sbq.push_back(expect_of(rows[c]));
            @(negedge clk);
            o = observe(); e = sbq.pop_front(); nchk++;
            if (o !== e) $display("FAIL async_reset_pre c%0d: got %h, expected %h", c, o, e);
            else npass++;
        end
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({mem_wr_en, grant_wr, mem_addr} !== 21'h0)
            $display("FAIL async_reset_clear: got wen=%b gwr=%b addr=%h, expected 0 0000 0000",
                     mem_wr_en, grant_wr, mem_addr);
        else npass++;
        req_rd = 4'b0011; req_wr = '0; wr_en = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        nchk++;
        if (grant_rd !== 4'b0001) $display("FAIL async_reset_ptr: got grant_rd=%b, expected 0001", grant_rd);
        else npass++;
        nchk++;
        if (mem_addr !== addr[0]) $display("FAIL async_reset_addr: got %h, expected %h", mem_addr, addr[0]);
        else npass++;
    endtask

    initial begin
        rst_n  = 1'b0;
        req_rd = '0; req_wr = '0; wr_en = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i]    = addr_t'(16'h0100 * (i + 1));
            wdata[i]   = 32'hC0DE_0000 + i;
            wr_size[i] = 3'(i + 1);
        end
        test_reset();
        test_single_proc();
        idle(2);
        test_two_procs();
        idle(2);
        test_lock_drop();
        idle(2);
        test_wr_prio();
        idle(2);
        test_async_reset();
        idle(2);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

`default_nettype wire
